axi4lite_master_bridge: RTL
===========================

Name: axi4lite_master_bridge

Overview:
- Converts the core's single-beat load/store request port into AXI4-Lite master transactions. It sits directly upstream of the AXI4-Lite slave peripherals (GPIO, etc.).
- Allows one outstanding transaction at a time.
- Reports the slave's response, or a bridge-generated timeout, on a valid/ready response port.
- A timed-out transaction is drained, so a late slave beat never gets matched to the next request.

Parameters:
- ADDR_WIDTH, `ALEN, address width of request and AXI channels.
- TIMEOUT_CYCLES, 1024, cycles allowed in response wait; 0 disables the timeout.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not overridden).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. Reset is asynchronous and active-low; all state clears immediately on assertion.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address, forwarded unmodified.
- req_wdata  in  64  write data.
- req_wstrb  in  8  write byte strobes.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  64  read data; 0 for writes and timeouts.
- resp_err  out  1  slave returned SLVERR/DECERR, or timeout.
- resp_timeout  out  1  error was a bridge timeout.
- awaddr, awprot(3), awvalid out; awready in.
- wdata(64), wstrb(8), wvalid out; wready in.
- bresp(2) in, bvalid in; bready out.
- araddr, arprot(3), arvalid out; arready in.
- rdata(64) in, rresp(2) in, rvalid in; rready out.

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN_W, DRAIN_R.
- Reset values:
  - state = IDLE.
  - All AXI valid/ready outputs = 0; awprot/arprot = 3'b000 (constant).
  - resp_valid = 0; resp_rdata = 0; resp_err = 0; resp_timeout = 0.
  - Counter = 0; latched addr/data/strb = 0.
- req_ready is combinational, = (state == IDLE).
- IDLE, on req_valid & req_ready:
  - Latch addr, wdata and wstrb.
  - Write: next cycle state = WR_REQ with awvalid = wvalid = 1.
  - Read: next cycle state = RD_REQ with arvalid = 1.
  - Minimum latency from accept to first AXI valid is 1 cycle.
- WR_REQ:
  - awvalid drops the cycle after its own handshake (awvalid & awready); wvalid likewise, independently.
  - AW and W may complete in either order or together.
  - Once both are done: state = WR_RESP, bready = 1, counter cleared.
  - Valids are never withdrawn before their handshake, and there is no timeout in WR_REQ/RD_REQ.
- RD_REQ: after arvalid & arready, arvalid = 0, rready = 1, state = RD_RESP, counter cleared.
- WR_RESP / RD_RESP:
  - The counter increments each cycle without a beat.
  - On bvalid (resp. rvalid): capture resp_err = resp[1]. For reads, capture resp_rdata = rdata; for writes, resp_rdata = 0.
  - On that beat: bready/rready = 0, resp_valid = 1, state = RESP.
- Timeout:
  - Fires when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no beat.
  - Then resp_valid = 1, resp_err = 1, resp_timeout = 1, resp_rdata = 0.
  - State goes to DRAIN_W/DRAIN_R; bready/rready stay 1.
  - A beat arriving in the same cycle as the timeout compare wins: normal response, no timeout.
- RESP: hold all resp_* stable until resp_ready; then resp_valid = 0 and state = IDLE. New requests are accepted from the following cycle.
- DRAIN_*:
  - resp_valid is handshaken as in RESP, independently of the drain.
  - The late beat is discarded; on it, bready/rready = 0.
  - Go to IDLE only when both the beat has arrived and the response has been consumed.
  - req_ready stays 0 throughout.
- resp_ready high while resp_valid is low has no effect.
- Async reset mid-transaction: all valids drop immediately and the transaction is lost. The slave must be reset by the same aresetn.

Test Plan:
- Write addr 0x10, wdata 0x0000_0001_0000_0001, wstrb 0x11; slave asserts awready and wready in the same cycle, bresp OKAY 2 cycles later -> awvalid/wvalid high exactly 1 cycle; resp_valid with resp_err = 0, resp_rdata = 0.
- Write with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until its handshake; one bready beat; single response.
- Read addr 0x8, slave returns rdata 0x0100_0000_0000_0001 with rresp SLVERR -> resp_rdata = 0x0100_0000_0000_0001, resp_err = 1, resp_timeout = 0.
- TIMEOUT_CYCLES = 4, read; slave never asserts rvalid -> 4 cycles after the AR handshake resp_valid = 1, resp_err = 1, resp_timeout = 1. Late rvalid 10 cycles later is drained; req_ready rises only after the drain and resp_ready.
- resp_ready held 0 for 5 cycles -> resp_* stable, req_ready = 0; the next request is accepted the cycle after resp_ready.
- aresetn dropped while awvalid = 1 -> awvalid, wvalid, resp_valid = 0 immediately (same cycle, no clock edge); state = IDLE after release.

Source files
------------

// File: rtl/axi4lite_master_bridge_if.sv
// AXI4-Lite bus between the master bridge and its downstream slave peripherals.
// The master modport drives the request channels; the slave modport returns the handshakes and responses.
`ifndef ALEN
`define ALEN 32
`endif

interface axi4lite_master_bridge_if #(
  parameter int ADDR_WIDTH = `ALEN
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [63:0]           wdata;
  logic [7:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [63:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding bridge from the core load/store port to AXI4-Lite, with a response
// timeout that drains the late beat so it can never be paired with a later request.
module axi4lite_master_bridge #(
  parameter int ADDR_WIDTH     = `ALEN,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CNT_WIDTH     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [7:0]            req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  axi4lite_master_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RESP    = 3'd5,
    DRAIN_W = 3'd6,
    DRAIN_R = 3'd7
  } state_t;

  state_t                state_r, state_n;
  logic                  awvalid_r, awvalid_n;
  logic                  wvalid_r, wvalid_n;
  logic                  arvalid_r, arvalid_n;
  logic                  bready_r, bready_n;
  logic                  rready_r, rready_n;
  logic                  resp_valid_r, resp_valid_n;
  logic [63:0]           resp_rdata_r, resp_rdata_n;
  logic                  resp_err_r, resp_err_n;
  logic                  resp_timeout_r, resp_timeout_n;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [63:0]           wdata_r, wdata_n;
  logic [7:0]            wstrb_r, wstrb_n;
  logic                  timeout_hit_s;
  logic                  unused_resp_s;

  // The counter value seen here is one below the cycles already waited, so the
  // error response appears exactly TIMEOUT_CYCLES cycles after the address handshake.
  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'sd0) &&
                         (cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 32'sd1));
  assign unused_resp_s = ^{axi.bresp[0], axi.rresp[0]};

  assign req_ready    = (state_r == IDLE);
  assign resp_valid   = resp_valid_r;
  assign resp_rdata   = resp_rdata_r;
  assign resp_err     = resp_err_r;
  assign resp_timeout = resp_timeout_r;
  assign axi.awaddr   = addr_r;
  assign axi.awprot   = 3'b000;
  assign axi.awvalid  = awvalid_r;
  assign axi.wdata    = wdata_r;
  assign axi.wstrb    = wstrb_r;
  assign axi.wvalid   = wvalid_r;
  assign axi.bready   = bready_r;
  assign axi.araddr   = addr_r;
  assign axi.arprot   = 3'b000;
  assign axi.arvalid  = arvalid_r;
  assign axi.rready   = rready_r;

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    state_n        = state_r;
    awvalid_n      = awvalid_r;
    wvalid_n       = wvalid_r;
    arvalid_n      = arvalid_r;
    bready_n       = bready_r;
    rready_n       = rready_r;
    resp_valid_n   = resp_valid_r;
    resp_rdata_n   = resp_rdata_r;
    resp_err_n     = resp_err_r;
    resp_timeout_n = resp_timeout_r;
    cnt_n          = cnt_r;
    addr_n         = addr_r;
    wdata_n        = wdata_r;
    wstrb_n        = wstrb_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          addr_n  = req_addr;
          wdata_n = req_wdata;
          wstrb_n = req_wstrb;
          if (req_write) begin
            state_n   = WR_REQ;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_REQ;
            arvalid_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; a channel already done stays low.
        awvalid_n = awvalid_r & ~axi.awready;
        wvalid_n  = wvalid_r & ~axi.wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
          cnt_n    = '0;
        end else begin
          state_n = WR_REQ;
        end
      end
      RD_REQ: begin
        if (axi.arready) begin
          state_n   = RD_RESP;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          cnt_n     = '0;
        end else begin
          state_n = RD_REQ;
        end
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          state_n        = RESP;
          bready_n       = 1'b0;
          resp_valid_n   = 1'b1;
          resp_err_n     = axi.bresp[1];
          resp_rdata_n   = 64'd0;
          resp_timeout_n = 1'b0;
        end else if (timeout_hit_s) begin
          state_n        = DRAIN_W;
          resp_valid_n   = 1'b1;
          resp_err_n     = 1'b1;
          resp_rdata_n   = 64'd0;
          resp_timeout_n = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_WIDTH'(1);
        end
      end
      RD_RESP: begin
        if (axi.rvalid) begin
          state_n        = RESP;
          rready_n       = 1'b0;
          resp_valid_n   = 1'b1;
          resp_err_n     = axi.rresp[1];
          resp_rdata_n   = axi.rdata;
          resp_timeout_n = 1'b0;
        end else if (timeout_hit_s) begin
          state_n        = DRAIN_R;
          resp_valid_n   = 1'b1;
          resp_err_n     = 1'b1;
          resp_rdata_n   = 64'd0;
          resp_timeout_n = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
        end else begin
          state_n = RESP;
        end
      end
      DRAIN_W: begin
        // Late beat and response handshake complete in any order; leave once both have.
        bready_n     = bready_r & ~axi.bvalid;
        resp_valid_n = resp_valid_r & ~resp_ready;
        if (!bready_n && !resp_valid_n) begin
          state_n = IDLE;
        end else begin
          state_n = DRAIN_W;
        end
      end
      DRAIN_R: begin
        rready_n     = rready_r & ~axi.rvalid;
        resp_valid_n = resp_valid_r & ~resp_ready;
        if (!rready_n && !resp_valid_n) begin
          state_n = IDLE;
        end else begin
          state_n = DRAIN_R;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by aresetn.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r        <= IDLE;
      awvalid_r      <= 1'b0;
      wvalid_r       <= 1'b0;
      arvalid_r      <= 1'b0;
      bready_r       <= 1'b0;
      rready_r       <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= 64'd0;
      resp_err_r     <= 1'b0;
      resp_timeout_r <= 1'b0;
      cnt_r          <= '0;
      addr_r         <= '0;
      wdata_r        <= 64'd0;
      wstrb_r        <= 8'd0;
    end else begin
      state_r        <= state_n;
      awvalid_r      <= awvalid_n;
      wvalid_r       <= wvalid_n;
      arvalid_r      <= arvalid_n;
      bready_r       <= bready_n;
      rready_r       <= rready_n;
      resp_valid_r   <= resp_valid_n;
      resp_rdata_r   <= resp_rdata_n;
      resp_err_r     <= resp_err_n;
      resp_timeout_r <= resp_timeout_n;
      cnt_r          <= cnt_n;
      addr_r         <= addr_n;
      wdata_r        <= wdata_n;
      wstrb_r        <= wstrb_n;
    end
  end

endmodule
